// File: rtl/fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_op_scheduler
//   Arbitrates two requesters onto one shared, fixed-latency FP datapath.
//   One operation is in flight at a time: IDLE -> START -> BUSY -> RESP.
//   Reserved ops (11) skip the datapath and answer with the canonical qNaN.
//
// Optional feature (compile-time macro): FPU_SCHED_NAN_BYPASS_EN
//   When defined, add/sub/mul with a NaN operand also skip the datapath
//   and answer with the canonical qNaN.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (2 bits)
//   req_op               2 bits per requester: 00 add, 01 sub, 10 mul, 11 rsvd
//   req_a, req_b         packed operands, requester i in [i*W +: W]
//   fpu_start            one-cycle launch pulse to the datapath
//   fpu_op, fpu_a, fpu_b latched operation, held until the response retires
//   fpu_result           datapath result, valid FPU_LATENCY cycles after start
//   resp_valid           one-hot result valid toward the owning requester
//   resp_ready           per-requester result accept
//   resp_data            result, stable while resp_valid is high
// ---------------------------------------------------------------------------
module fpu_op_scheduler #(
  parameter int SIGN_WIDTH        = 1,
  parameter int EXPONENT_WIDTH    = 11,
  parameter int SIGNIFICAND_WIDTH = 52,
  parameter int FPU_LATENCY       = 4
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic [1:0]                                                   req_valid,
  output logic [1:0]                                                   req_ready,
  input  logic [3:0]                                                   req_op,
  input  logic [2*(SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH)-1:0]   req_a,
  input  logic [2*(SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH)-1:0]   req_b,
  output logic                                                         fpu_start,
  output logic [1:0]                                                   fpu_op,
  output logic [SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH-1:0]       fpu_a,
  output logic [SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH-1:0]       fpu_b,
  input  logic [SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH-1:0]       fpu_result,
  output logic [1:0]                                                   resp_valid,
  input  logic [1:0]                                                   resp_ready,
  output logic [SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH-1:0]       resp_data
);

  localparam int W = SIGN_WIDTH + EXPONENT_WIDTH + SIGNIFICAND_WIDTH;

  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [3:0] CNT_INIT = 4'(FPU_LATENCY - 1);

  // Canonical quiet NaN: sign 0, exponent all ones, significand MSB only.
  localparam logic [W-1:0] QNAN = {{SIGN_WIDTH{1'b0}}, {EXPONENT_WIDTH{1'b1}},
                                   1'b1, {(SIGNIFICAND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_RESP
  } state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic           owner_q;      // requester that owns the in-flight op
  logic           last_q;       // requester granted most recently
  logic           fpu_start_q;
  logic [1:0]     fpu_op_q;
  logic [W-1:0]   fpu_a_q;
  logic [W-1:0]   fpu_b_q;
  logic [1:0]     resp_valid_q;
  logic [W-1:0]   resp_data_q;

  logic           grant_id;
  logic           grant_any;
  logic [1:0]     sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           bypass;

  // Round-robin pick: on a tie the requester not granted last wins.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_id = req_valid[1];
    if (req_valid == 2'b11) grant_id = ~last_q;
  end

  assign grant_any = (state_q == S_IDLE) && (|req_valid);
  // The grant is combinational so a request withdrawn before this cycle
  // is never accepted.
  assign req_ready = grant_any ? (2'b01 << grant_id) : 2'b00;

  assign sel_op = grant_id ? req_op[3:2]   : req_op[1:0];
  assign sel_a  = grant_id ? req_a[W +: W] : req_a[0 +: W];
  assign sel_b  = grant_id ? req_b[W +: W] : req_b[0 +: W];

`ifdef FPU_SCHED_NAN_BYPASS_EN
  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[SIGNIFICAND_WIDTH +: EXPONENT_WIDTH]) && (|x[SIGNIFICAND_WIDTH-1:0]);
  endfunction

  assign bypass = (sel_op == OP_RSVD) || is_nan(sel_a) || is_nan(sel_b);
`else
  assign bypass = (sel_op == OP_RSVD);
`endif

  // NOTE: state is updated with non-blocking assignments and the reset is
  // sampled on the clock edge, so a mid-operation reset simply drops the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      fpu_start_q  <= 1'b0;
      fpu_op_q     <= 2'b00;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      fpu_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_any) begin
            owner_q  <= grant_id;
            fpu_op_q <= sel_op;
            fpu_a_q  <= sel_a;
            fpu_b_q  <= sel_b;
            if (bypass) begin
              resp_data_q  <= QNAN;
              resp_valid_q <= 2'b01 << grant_id;
              state_q      <= S_RESP;
            end else begin
              fpu_start_q <= 1'b1;      // high throughout START
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          cnt_q   <= CNT_INIT;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          // Counter reaching 0 marks the cycle fpu_result is valid.
          if (cnt_q == 4'd0) begin
            resp_data_q  <= fpu_result;
            resp_valid_q <= 2'b01 << owner_q;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Only the owner's accept retires the response.
          if (resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            last_q       <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fpu_start  = fpu_start_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_scheduler
//   Directed bench for fpu_op_scheduler at default (double precision)
//   parameters. Stimulus pushes the hand-computed response into a
//   scoreboard queue; a monitor pops and compares on each response
//   handshake. A small FP datapath stand-in returns hand-computed results
//   exactly FPU_LATENCY cycles after fpu_start and junk at all other times.
//   Honours FPU_SCHED_NAN_BYPASS_EN for the NaN operand case.
// ---------------------------------------------------------------------------
module tb_fpu_op_scheduler;

  localparam int W   = 64;
  localparam int LAT = 4;

  localparam logic [63:0] ONE   = 64'h3FF0000000000000;  // 1.0
  localparam logic [63:0] TWO   = 64'h4000000000000000;  // 2.0
  localparam logic [63:0] THREE = 64'h4008000000000000;  // 3.0
  localparam logic [63:0] SIX   = 64'h4018000000000000;  // 6.0
  localparam logic [63:0] SNAN  = 64'h7FF0000000000001;  // signalling NaN
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;  // canonical qNaN
  localparam logic [63:0] QSNAN = 64'h7FF8000000000001;  // SNAN quieted
  localparam logic [63:0] JUNK  = 64'hDEADBEEFDEADBEEF;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [3:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           fpu_start;
  logic [1:0]     fpu_op;
  logic [W-1:0]   fpu_a;
  logic [W-1:0]   fpu_b;
  logic [W-1:0]   fpu_result;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [W-1:0]   resp_data;

  fpu_op_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- datapath stand-in ----------------
  function automatic logic [63:0] fp_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 2'b00 && a == ONE  && b == TWO)   return THREE;  // 1+2
    if (op == 2'b01 && a == TWO  && b == ONE)   return ONE;    // 2-1
    if (op == 2'b10 && a == TWO  && b == THREE) return SIX;    // 2*3
    if (op == 2'b00 && a == SNAN && b == ONE)   return QSNAN;  // NaN propagates quieted
    return JUNK;
  endfunction

  logic [64:0] pipe [LAT];
  initial for (int k = 0; k < LAT; k++) pipe[k] = '0;

  always @(posedge clk) begin
    pipe[0] <= {fpu_start, fp_model(fpu_op, fpu_a, fpu_b)};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign fpu_result = pipe[LAT-1][64] ? pipe[LAT-1][63:0] : JUNK;

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  int n_start = 0;
  always @(negedge clk) if (!rst && fpu_start) n_start++;

  // Response monitor: checks hold stability and pops on each handshake.
  initial begin
    bit          hold_active;
    logic [1:0]  hold_v;
    logic [63:0] hold_d;
    exp_t        e;
    hold_active = 1'b0;
    hold_v      = '0;
    hold_d      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_active = 1'b0;
        continue;
      end
      if (req_ready != 2'b00) check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
      if (resp_valid != 2'b00) begin
        if (hold_active) begin
          check("resp_hold_valid", resp_valid, hold_v);
          check("resp_hold_data", resp_data, hold_d);
        end
        hold_v      = resp_valid;
        hold_d      = resp_data;
        hold_active = ((resp_valid & resp_ready) == 2'b00);
        if (!hold_active) begin
          if (sb.size() == 0) begin
            check("resp_unexpected", resp_valid, 64'd0);
          end else begin
            e = sb.pop_front();
            check("resp_owner", resp_valid, 64'(2'b01 << e.id));
            check("resp_data", resp_data, e.data);
          end
        end
      end else begin
        hold_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(input int id, output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1'b1;
        g   = cyc;
        check("grant_id", req_ready, 64'(2'b01 << id));
      end
    end
    check("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic run_op(input int id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_d, input int exp_lat, input int exp_starts);
    int g, s0;
    bit seen;
    sb.push_back('{id[0], exp_d});
    req_op[id*2 +: 2] = op;
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
    req_valid[id]     = 1'b1;
    wait_grant(id, g);
    s0 = n_start;
    @(posedge clk); #1 req_valid[id] = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (k == 1 && exp_starts == 1) begin
        check("fpu_op_latched", fpu_op, op);
        check("fpu_a_latched", fpu_a, a);
        check("fpu_b_latched", fpu_b, b);
      end
      if (resp_valid != 2'b00) seen = 1'b1;
    end
    check("resp_seen", 64'(seen), 64'd1);
    check("resp_latency", 64'(cyc - g), 64'(exp_lat));
    @(posedge clk); #1;
    check("fpu_start_count", 64'(n_start - s0), 64'(exp_starts));
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g, prev, hs;
    bit seen;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 64'd0);
    check("rst_resp_valid", resp_valid, 64'd0);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_fpu_op", fpu_op, 64'd0);
    check("rst_fpu_a", fpu_a, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    @(posedge clk); #1;

    // Basic ops: response at grant+6, one launch each
    run_op(0, 2'b00, ONE, TWO, THREE, 6, 1);
    run_op(1, 2'b01, TWO, ONE, ONE, 6, 1);
    run_op(0, 2'b10, TWO, THREE, SIX, 6, 1);
    // Reserved op bypasses the datapath
    run_op(1, 2'b11, ONE, TWO, QNAN, 1, 0);
    // NaN operand
`ifdef FPU_SCHED_NAN_BYPASS_EN
    run_op(0, 2'b00, SNAN, ONE, QNAN, 1, 0);
`else
    run_op(0, 2'b00, SNAN, ONE, QSNAN, 6, 1);
`endif

    // Reset in BUSY abandons the op
    req_op[3:2]   = 2'b00;
    req_a[W +: W] = ONE;
    req_b[W +: W] = TWO;
    req_valid[1]  = 1'b1;
    wait_grant(1, g);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", resp_valid, 64'd0);
    check("midrst_fpu_start", 64'(fpu_start), 64'd0);
    check("midrst_fpu_op", fpu_op, 64'd0);
    check("midrst_fpu_a", fpu_a, 64'd0);
    check("midrst_fpu_b", fpu_b, 64'd0);
    check("midrst_resp_data", resp_data, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Both valid continuously: 0,1,0,1 with 7-cycle spacing
    req_op       = 4'b10_00;          // req1 mul, req0 add
    req_a        = {TWO, ONE};
    req_b        = {THREE, TWO};
    sb.push_back('{1'b0, THREE});
    sb.push_back('{1'b1, SIX});
    sb.push_back('{1'b0, THREE});
    sb.push_back('{1'b1, SIX});
    req_valid = 2'b11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(i % 2, g);
      if (i > 0) check("grant_spacing", 64'(g - prev), 64'd7);
      prev = g;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    drain();
    @(posedge clk); #1;

    // Back-pressure on req0 while req1 waits; last grant was 1 so 0 wins
    req_op     = 4'b01_00;            // req1 sub, req0 add
    req_a      = {TWO, ONE};
    req_b      = {ONE, TWO};
    sb.push_back('{1'b0, THREE});
    sb.push_back('{1'b1, ONE});
    resp_ready = 2'b10;
    req_valid  = 2'b11;
    wait_grant(0, g);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen = 1'b1;
    end
    check("bp_resp_seen", 64'(seen), 64'd1);
    check("bp_resp_latency", 64'(cyc - g), 64'd6);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid_held", resp_valid, 64'd1);
      check("bp_data_held", resp_data, THREE);
      check("bp_no_grant", req_ready, 64'd0);
    end
    @(posedge clk); #1 resp_ready = 2'b11;
    hs = cyc;
    wait_grant(1, g);
    check("bp_grant_after_hs", 64'(g - hs), 64'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_op_scheduler.md
FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

Interface
REQ-001 Parameter: SIGN_WIDTH, default 1, sign field width.
REQ-002 Parameter: EXPONENT_WIDTH, default 11, exponent field width.
REQ-003 Parameter: SIGNIFICAND_WIDTH, default 52, stored significand width; W = SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH.
REQ-004 Parameter: FPU_LATENCY, default 4, number of cycles from the fpu_start cycle to the fpu_result-valid cycle; legal range 1..15.
REQ-005 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: req_valid  in  2  per-requester operation request.
REQ-008 Port: req_ready  out  2  per-requester accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 Port: req_op  in  4  2 bits per requester: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-010 Port: req_a, req_b  in  2*W each  packed operands, requester i in bits [i*W +: W].
REQ-011 Port: fpu_start  out  1  single-cycle launch pulse to the shared FP datapath.
REQ-012 Port: fpu_op  out  2; fpu_a, fpu_b  out  W  latched operation and operands, stable from START until RESP exit.
REQ-013 Port: fpu_result  in  W  datapath result, valid exactly FPU_LATENCY cycles after the fpu_start cycle.
REQ-014 Port: resp_valid  out  2  one-hot result valid toward the owning requester.
REQ-015 Port: resp_ready  in  2  per-requester result accept.
REQ-016 Port: resp_data  out  W  result, held stable while any resp_valid bit is high.

Function
REQ-017 The FSM SHALL have states IDLE, START, BUSY and RESP; at most one operation is in flight.
REQ-018 IDLE: if any req_valid is high, grant g (round-robin: when both are valid, the requester not granted last wins), assert req_ready[g] only, latch op/operands, capture g; go to START.
REQ-019 req_ready SHALL be high only in the IDLE grant cycle, never for both requesters, and never in any other state.
REQ-020 START: fpu_start=1 for exactly one cycle; load the counter with FPU_LATENCY-1; go to BUSY.
REQ-021 BUSY: decrement the counter each cycle; in the cycle the counter is 0, register fpu_result into resp_data; go to RESP.
REQ-022 RESP: resp_valid[g]=1; hold it until resp_ready[g]=1, then go to IDLE and record g as last grant; resp_ready[!g] SHALL be ignored.
REQ-023 An op of 11 SHALL bypass START/BUSY: IDLE goes directly to RESP with resp_data = canonical qNaN (sign 0, exponent all ones, significand MSB 1, rest 0).
REQ-024 A request arriving in any non-IDLE state SHALL wait; req_valid deasserting before grant is legal and SHALL NOT be granted.
REQ-025 Minimum turnaround (resp_ready held high) SHALL be FPU_LATENCY+3 cycles from grant to the next grant.

Reset
REQ-026 On rst: state IDLE; req_ready, resp_valid and fpu_start = 0; resp_data, fpu_a, fpu_b = 0; fpu_op = 00; counter = 0; last grant = 1, so requester 0 wins the first tie.
REQ-027 rst asserted mid-operation SHALL abandon the operation without producing any response, and the FSM SHALL ignore fpu_result after reset.

Configuration
REQ-028 With macro FPU_SCHED_NAN_BYPASS_EN defined, a granted add/sub/mul with either operand NaN (exponent all ones, significand nonzero) SHALL skip START/BUSY and go to RESP with the canonical qNaN; fpu_start is never pulsed for it.
REQ-029 Without FPU_SCHED_NAN_BYPASS_EN, NaN operands SHALL be sequenced through the datapath like any other operands; the reserved-op bypass (REQ-023) is unaffected.

Verification (default parameters, double precision)
REQ-030 Req0 add a=0x3FF0000000000000, b=0x4000000000000000; model returns 0x4008000000000000 -> req_ready[0] for 1 cycle, fpu_start 1 cycle later, resp_valid[0] with resp_data 0x4008000000000000 at grant+6 cycles.
REQ-031 Both requesters valid continuously, resp_ready=11 -> grants alternate 0,1,0,1; no req_ready overlap; grant spacing 7 cycles.
REQ-032 resp_ready[0] held low for 5 cycles in RESP -> resp_valid[0] and resp_data stay stable; req1 is not granted until the cycle after the response handshake.
REQ-033 req_op=11 from req1 -> no fpu_start; resp_valid[1] at grant+1 with resp_data 0x7FF8000000000000.
REQ-034 rst pulsed in BUSY -> all outputs return to reset values next cycle; no resp_valid; the next tie goes to requester 0.
REQ-035 a=0x7FF0000000000001 add: with FPU_SCHED_NAN_BYPASS_EN, no fpu_start and resp 0x7FF8000000000000 at grant+1; without it, a normal FPU_LATENCY sequence.
